// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: load-use bubbles, control-transfer redirects and
// the instruction-memory shadow after a redirect, plus saturating event counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal flow; load-use hazards insert a single bubble
// ST_SHADOW | wrong-path fetches still arriving; IF/ID is squashed
module ex_hazard_ctrl #(
    parameter int SHADOW_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_raddr_ID,
    input  logic [4:0]       rs2_raddr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_waddr_EX,
    input  logic             rd_wen_EX,
    input  logic [1:0]       PMAItoReg_EX,
    input  logic             branch_EX,
    input  logic             branch_taken_EX,
    input  logic             jal_EX,
    input  logic             jalr_EX,
    input  logic             mem_stall,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             redirect,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    localparam logic [2:0]       SHADOW_LOAD = 3'(SHADOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t     state, state_nxt;
    logic [2:0] shadow_cnt, shadow_nxt;
    logic       bubble_inc, flush_inc;
    logic       take, load_use, rs1_hit, rs2_hit;

    assign take    = jal_EX | jalr_EX | (branch_EX & branch_taken_EX);
    assign rs1_hit = rs1_used_ID && (rs1_raddr_ID == rd_waddr_EX);
    assign rs2_hit = rs2_used_ID && (rs2_raddr_ID == rd_waddr_EX);
    // x0 is hardwired, so a load targeting it can never be a real dependency.
    assign load_use = (PMAItoReg_EX == 2'b01) && rd_wen_EX && (rd_waddr_EX != 5'd0)
                      && (rs1_hit || rs2_hit);

    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        stall_id_ex = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        redirect    = 1'b0;
        state_nxt   = state;
        shadow_nxt  = shadow_cnt;
        bubble_inc  = 1'b0;
        flush_inc   = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                // EX is held, so a pending take is simply re-seen once the stall lifts.
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                stall_id_ex = 1'b1;
            end else if (take) begin
                redirect    = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                flush_inc   = 1'b1;
                if (SHADOW_CYCLES > 0) begin
                    state_nxt  = ST_SHADOW;
                    shadow_nxt = SHADOW_LOAD;
                end
            end else if (state == ST_SHADOW) begin
                // ID holds a wrong-path instruction, so its hazards are ignored.
                flush_if_id = 1'b1;
                shadow_nxt  = shadow_cnt - 3'd1;
                if (shadow_cnt == 3'd1) begin
                    state_nxt = ST_RUN;
                end
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
                bubble_inc  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            shadow_cnt <= 3'd0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            shadow_cnt <= shadow_nxt;
            if (bubble_inc && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed and random checks of ex_hazard_ctrl against a behavioural model that
// tracks remaining shadow cycles and event counts as plain integers.
module tb_ex_hazard_ctrl;

    localparam int SC    = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_raddr_ID, rs2_raddr_ID, rd_waddr_EX;
    logic             rs1_used_ID, rs2_used_ID, rd_wen_EX;
    logic [1:0]       PMAItoReg_EX;
    logic             branch_EX, branch_taken_EX, jal_EX, jalr_EX, mem_stall;
    logic             stall_pc, stall_if_id, stall_id_ex;
    logic             flush_if_id, flush_id_ex, redirect;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_shadow_left = 0;
    int m_bub         = 0;
    int m_fl          = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.SHADOW_CYCLES(SC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_raddr_ID(rs1_raddr_ID), .rs2_raddr_ID(rs2_raddr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_waddr_EX(rd_waddr_EX), .rd_wen_EX(rd_wen_EX),
        .PMAItoReg_EX(PMAItoReg_EX), .branch_EX(branch_EX),
        .branch_taken_EX(branch_taken_EX), .jal_EX(jal_EX), .jalr_EX(jalr_EX),
        .mem_stall(mem_stall),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .redirect(redirect),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; mem_stall = 1'b0;
        rs1_raddr_ID = 5'd0; rs2_raddr_ID = 5'd0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
        rd_waddr_EX = 5'd0; rd_wen_EX = 1'b0; PMAItoReg_EX = 2'b00;
        branch_EX = 1'b0; branch_taken_EX = 1'b0; jal_EX = 1'b0; jalr_EX = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] src, input bit use_rs2);
        PMAItoReg_EX = 2'b01; rd_wen_EX = 1'b1; rd_waddr_EX = rd;
        if (use_rs2) begin
            rs2_raddr_ID = src; rs2_used_ID = 1'b1;
        end else begin
            rs1_raddr_ID = src; rs1_used_ID = 1'b1;
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge, check counters after.
    task automatic cycle(input string tag);
        bit       take, lu;
        bit [5:0] exp;
        #1;
        take = jal_EX || jalr_EX || (branch_EX && branch_taken_EX);
        lu   = (PMAItoReg_EX == 2'b01) && rd_wen_EX && (rd_waddr_EX != 0) &&
               ((rs1_used_ID && rs1_raddr_ID == rd_waddr_EX) ||
                (rs2_used_ID && rs2_raddr_ID == rd_waddr_EX));
        // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, redirect}
        if (rst)                    exp = 6'b000000;
        else if (mem_stall)         exp = 6'b111000;
        else if (take)              exp = 6'b000111;
        else if (m_shadow_left > 0) exp = 6'b000100;
        else if (lu)                exp = 6'b110010;
        else                        exp = 6'b000000;
        chk({tag, ".ctl"}, {26'd0, stall_pc, stall_if_id, stall_id_ex,
                            flush_if_id, flush_id_ex, redirect}, {26'd0, exp});
        @(posedge clk);
        if (rst) begin
            m_shadow_left = 0; m_bub = 0; m_fl = 0;
        end else if (!mem_stall) begin
            if (take) begin
                m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
                m_shadow_left = SC;
            end else if (m_shadow_left > 0) begin
                m_shadow_left--;
            end else if (lu) begin
                m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
            end
        end
        @(negedge clk);
        chk({tag, ".bub"}, 32'(bubble_cnt), 32'(m_bub));
        chk({tag, ".fl"},  32'(flush_cnt),  32'(m_fl));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cycle("rst0");
        cycle("rst1");
        chk("rst_bub_zero", 32'(bubble_cnt), 32'd0);

        // load x5, ID reads rs2=x5: single bubble
        idle(); set_load_use(5'd5, 5'd5, 1'b1);
        cycle("lu_x5");
        chk("lu_x5_bub1", 32'(bubble_cnt), 32'd1);
        idle(); cycle("lu_after");

        // load to x0 never hazards
        idle(); set_load_use(5'd0, 5'd0, 1'b0);
        cycle("lu_x0");
        chk("lu_x0_bub", 32'(bubble_cnt), 32'd1);

        // jal with a two-cycle shadow
        idle(); jal_EX = 1'b1; cycle("jal_c0");
        idle(); cycle("jal_c1"); cycle("jal_c2"); cycle("jal_c3");
        chk("jal_fl1", 32'(flush_cnt), 32'd1);

        // taken branch held by mem_stall for three cycles
        idle(); branch_EX = 1'b1; branch_taken_EX = 1'b1; mem_stall = 1'b1;
        cycle("ms_c0"); cycle("ms_c1"); cycle("ms_c2");
        chk("ms_fl_frozen", 32'(flush_cnt), 32'd1);
        mem_stall = 1'b0; cycle("ms_redir");
        chk("ms_fl2", 32'(flush_cnt), 32'd2);
        idle(); cycle("ms_sh1"); cycle("ms_sh2");

        // load-use inside shadow is ignored, then reset mid-shadow
        idle(); jalr_EX = 1'b1; cycle("sh_jalr");
        idle(); set_load_use(5'd7, 5'd7, 1'b0); cycle("sh_lu");
        chk("sh_lu_nobub", 32'(bubble_cnt), 32'd1);
        rst = 1'b1; cycle("sh_rst");
        idle(); cycle("sh_post");
        chk("sh_post_fl0", 32'(flush_cnt), 32'd0);

        // bubble counter saturation
        idle(); set_load_use(5'd9, 5'd9, 1'b1);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle("sat");
        chk("sat_hold", 32'(bubble_cnt), 32'(CMAX));

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            mem_stall       = ($urandom_range(0, 3) == 0);
            rs1_raddr_ID    = 5'($urandom_range(0, 3));
            rs2_raddr_ID    = 5'($urandom_range(0, 3));
            rs1_used_ID     = 1'($urandom_range(0, 1));
            rs2_used_ID     = 1'($urandom_range(0, 1));
            rd_waddr_EX     = 5'($urandom_range(0, 3));
            rd_wen_EX       = ($urandom_range(0, 3) != 0);
            PMAItoReg_EX    = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            branch_EX       = ($urandom_range(0, 5) == 0);
            branch_taken_EX = 1'($urandom_range(0, 1));
            jal_EX          = ($urandom_range(0, 11) == 0);
            jalr_EX         = ($urandom_range(0, 11) == 0);
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
